// File: rtl/aes_round_sequencer_if.sv
// Handshake and datapath-control bundle between the AES round sequencer,
// the encrypt/decrypt requesters, key storage and the round datapath.
interface aes_round_sequencer_if #(
  parameter int RCNT_W = 4
);
  logic              enc_req;
  logic              dec_req;
  logic              key_ready;
  logic              out_ready;
  logic              enc_grant;
  logic              dec_grant;
  logic              mode;
  logic              load_block;
  logic              round_en;
  logic              final_round;
  logic [RCNT_W-1:0] round_num;
  logic [RCNT_W-1:0] key_sel;
  logic              out_valid;
  logic              clear;
  logic              busy;

  // Sequencer side
  modport master (
    input  enc_req, dec_req, key_ready, out_ready,
    output enc_grant, dec_grant, mode, load_block, round_en, final_round,
           round_num, key_sel, out_valid, clear, busy
  );

  // Requester / datapath side
  modport slave (
    output enc_req, dec_req, key_ready, out_ready,
    input  enc_grant, dec_grant, mode, load_block, round_en, final_round,
           round_num, key_sel, out_valid, clear, busy
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Round-robin arbiter and round sequencer for the shared AES round datapath.
// Control outputs are registered: they are decoded from the next state and
// captured together with it, so they line up with the state they describe.
// clear is the only combinational output (out_valid qualified by out_ready).
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int RCNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  aes_round_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam logic [RCNT_W-1:0] LAST_RND = RCNT_W'(NUM_ROUNDS);
  localparam logic [RCNT_W-1:0] PENULT   = RCNT_W'(NUM_ROUNDS - 1);
  localparam logic [RCNT_W-1:0] ZERO     = {RCNT_W{1'b0}};
  localparam logic [RCNT_W-1:0] ONE      = RCNT_W'(1);

  state_t            state_r, state_s;
  logic [RCNT_W-1:0] round_num_r, round_num_s;
  logic              mode_r, mode_s;
  logic              last_served_r, last_served_s;  // 1 = decrypt served last

  logic              enc_grant_r, enc_grant_s;
  logic              dec_grant_r, dec_grant_s;
  logic              load_block_r, load_block_s;
  logic              round_en_r, round_en_s;
  logic              final_round_r, final_round_s;
  logic [RCNT_W-1:0] key_sel_r, key_sel_s;
  logic              out_valid_r, out_valid_s;
  logic              busy_r, busy_s;

  // Next-state, round counter, arbitration and decode of the next-cycle outputs
  always_comb begin
    state_s       = state_r;
    round_num_s   = round_num_r;
    mode_s        = mode_r;
    last_served_s = last_served_r;

    case (state_r)
      IDLE: begin
        if (bus.key_ready && (bus.enc_req || bus.dec_req)) begin
          // On a tie the requester not served last wins
          if (bus.enc_req && bus.dec_req) begin
            mode_s = ~last_served_r;
          end else begin
            mode_s = bus.dec_req;
          end
          state_s     = LOAD;
          round_num_s = ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s     = ROUND;
        round_num_s = ONE;
      end
      ROUND: begin
        round_num_s = round_num_r + ONE;
        if (round_num_r == PENULT) begin
          state_s = FINAL;
        end else begin
          state_s = ROUND;
        end
      end
      FINAL: begin
        state_s     = OUT;
        round_num_s = LAST_RND;
      end
      OUT: begin
        if (bus.out_ready) begin
          state_s       = IDLE;
          round_num_s   = ZERO;
          last_served_s = mode_r;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s     = IDLE;
        round_num_s = ZERO;
      end
    endcase

    enc_grant_s   = 1'b0;
    dec_grant_s   = 1'b0;
    load_block_s  = 1'b0;
    round_en_s    = 1'b0;
    final_round_s = 1'b0;
    key_sel_s     = ZERO;
    out_valid_s   = 1'b0;
    busy_s        = (state_s != IDLE);

    case (state_s)
      LOAD: begin
        enc_grant_s  = ~mode_s;
        dec_grant_s  = mode_s;
        load_block_s = 1'b1;
        key_sel_s    = mode_s ? LAST_RND : ZERO;
      end
      ROUND: begin
        round_en_s = 1'b1;
        key_sel_s  = mode_s ? (LAST_RND - round_num_s) : round_num_s;
      end
      FINAL: begin
        round_en_s    = 1'b1;
        final_round_s = 1'b1;
        key_sel_s     = mode_s ? ZERO : LAST_RND;
      end
      OUT: begin
        out_valid_s = 1'b1;
      end
      default: begin
        key_sel_s = ZERO;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_r       <= IDLE;
      round_num_r   <= ZERO;
      mode_r        <= 1'b0;
      last_served_r <= 1'b1;
      enc_grant_r   <= 1'b0;
      dec_grant_r   <= 1'b0;
      load_block_r  <= 1'b0;
      round_en_r    <= 1'b0;
      final_round_r <= 1'b0;
      key_sel_r     <= ZERO;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      round_num_r   <= round_num_s;
      mode_r        <= mode_s;
      last_served_r <= last_served_s;
      enc_grant_r   <= enc_grant_s;
      dec_grant_r   <= dec_grant_s;
      load_block_r  <= load_block_s;
      round_en_r    <= round_en_s;
      final_round_r <= final_round_s;
      key_sel_r     <= key_sel_s;
      out_valid_r   <= out_valid_s;
      busy_r        <= busy_s;
    end
  end

  assign bus.enc_grant   = enc_grant_r;
  assign bus.dec_grant   = dec_grant_r;
  assign bus.mode        = mode_r;
  assign bus.load_block  = load_block_r;
  assign bus.round_en    = round_en_r;
  assign bus.final_round = final_round_r;
  assign bus.round_num   = round_num_r;
  assign bus.key_sel     = key_sel_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.clear       = out_valid_r & bus.out_ready;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_aes_round_sequencer;

  localparam int NR = 10;
  localparam int RW = 4;

  logic clk;
  logic n_rst;

  aes_round_sequencer_if #(.RCNT_W(RW)) bus ();

  aes_round_sequencer #(.NUM_ROUNDS(NR), .RCNT_W(RW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a block is "active" from grant until accepted; step counts
  // cycles since the grant (0 = load, 1..NR = rounds, NR+1 = waiting output).
  bit m_valid    = 1'b0;
  bit m_active   = 1'b0;
  int m_step     = 0;
  bit m_mode     = 1'b0;
  bit m_last_dec = 1'b1;

  // Grant log used to check round-robin alternation and spacing
  bit log_en = 1'b0;
  int grant_cyc[$];
  bit grant_dec[$];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply one cycle of inputs, check outputs against the model, advance the model
  task automatic step_cycle(input bit rst, input bit e, input bit d, input bit k, input bit o);
    int exp_rn;
    int exp_ks;
    bit exp_ov;
    @(posedge clk);
    #1;
    n_rst         = rst;
    bus.enc_req   = e;
    bus.dec_req   = d;
    bus.key_ready = k;
    bus.out_ready = o;
    @(negedge clk);
    cyc++;

    if (m_valid) begin
      exp_ov = m_active && (m_step == NR + 1);
      if (!m_active)          exp_rn = 0;
      else if (m_step > NR)   exp_rn = NR;
      else                    exp_rn = m_step;
      if (!m_active)          exp_ks = 0;
      else if (m_step == 0)   exp_ks = m_mode ? NR : 0;
      else if (m_step <= NR)  exp_ks = m_mode ? (NR - m_step) : m_step;
      else                    exp_ks = 0;

      check_value("enc_grant",   32'(bus.enc_grant),   32'(m_active && m_step == 0 && !m_mode));
      check_value("dec_grant",   32'(bus.dec_grant),   32'(m_active && m_step == 0 && m_mode));
      check_value("mode",        32'(bus.mode),        32'(m_mode));
      check_value("load_block",  32'(bus.load_block),  32'(m_active && m_step == 0));
      check_value("round_en",    32'(bus.round_en),    32'(m_active && m_step >= 1 && m_step <= NR));
      check_value("final_round", 32'(bus.final_round), 32'(m_active && m_step == NR));
      check_value("round_num",   32'(bus.round_num),   32'(exp_rn));
      check_value("key_sel",     32'(bus.key_sel),     32'(exp_ks));
      check_value("out_valid",   32'(bus.out_valid),   32'(exp_ov));
      check_value("clear",       32'(bus.clear),       32'(exp_ov && o));
      check_value("busy",        32'(bus.busy),        32'(m_active));
      check_value("one_strobe",  32'(bus.load_block && bus.round_en), 32'(0));
      check_value("one_grant",   32'(bus.enc_grant && bus.dec_grant), 32'(0));
    end

    if (log_en && (bus.enc_grant || bus.dec_grant)) begin
      grant_cyc.push_back(cyc);
      grant_dec.push_back(bus.dec_grant);
    end

    if (rst) begin
      m_valid    = 1'b1;
      m_active   = 1'b0;
      m_step     = 0;
      m_mode     = 1'b0;
      m_last_dec = 1'b1;
    end else if (!m_active) begin
      if (k && (e || d)) begin
        m_mode   = (e && d) ? !m_last_dec : d;
        m_active = 1'b1;
        m_step   = 0;
      end
    end else if (m_step <= NR) begin
      m_step++;
    end else if (o) begin
      m_active   = 1'b0;
      m_last_dec = m_mode;
      m_step     = 0;
    end
  endtask

  task automatic run(input int n, input bit rst, input bit e, input bit d, input bit k, input bit o);
    for (int i = 0; i < n; i++) step_cycle(rst, e, d, k, o);
  endtask

  initial begin
    n_rst         = 1'b1;
    bus.enc_req   = 1'b0;
    bus.dec_req   = 1'b0;
    bus.key_ready = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    run(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Single encrypt block, request held only until granted
    run(2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Single decrypt block
    run(2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run(14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Both requesting continuously: alternating grants 13 cycles apart
    log_en = 1'b1;
    run(60, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    log_en = 1'b0;
    check_value("rr_grant_count", 32'(grant_cyc.size() >= 4), 32'(1));
    if (grant_cyc.size() > 0) check_value("rr_first_enc", 32'(grant_dec[0]), 32'(0));
    for (int i = 1; i < grant_cyc.size(); i++) begin
      check_value("rr_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'(13));
      check_value("rr_alternate", 32'(grant_dec[i] != grant_dec[i-1]), 32'(1));
    end
    run(14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // key_ready low blocks the grant
    run(5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run(2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Consumer stalls for 4 cycles in OUT
    run(1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of the rounds with encrypt request held
    run(6,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    run(2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Dropped request before grant: stays idle
    run(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step_cycle(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Sequences the shared AES round datapath between the two users of the SD-card encryption ASIC: the write path (encrypt requester) and the read path (decrypt requester). It arbitrates round-robin between the two requests and latches the winner's mode. It then drives the datapath's load/round strobes, round counter and round-key index through one full block, and holds the result until the consumer accepts it. It sits between the SD-side block buffers and the AES round datapath / key-expansion storage.

## Interface
- NUM_ROUNDS, 10, number of AES rounds (10 for AES-128)
- RCNT_W, 4, width of round counter and key index; must hold NUM_ROUNDS
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  reset, synchronous, active-high (1 = reset); named per codebase convention
- enc_req  input  1  encrypt requester wants the datapath; held until enc_grant
- dec_req  input  1  decrypt requester wants the datapath; held until dec_grant
- key_ready  input  1  key expansion complete, all round keys valid
- out_ready  input  1  consumer accepts finished block
- enc_grant  output  1  one-cycle grant pulse to encrypt requester
- dec_grant  output  1  one-cycle grant pulse to decrypt requester
- mode  output  1  latched operation: 0 encrypt, 1 decrypt
- load_block  output  1  datapath loads input block XOR round key key_sel
- round_en  output  1  datapath performs one round this cycle
- final_round  output  1  current round omits MixColumns (with round_en)
- round_num  output  RCNT_W  current round, 0..NUM_ROUNDS
- key_sel  output  RCNT_W  round-key index to key storage
- out_valid  output  1  datapath output register holds finished block
- clear  output  1  datapath/requester clear pulse, = out_valid & out_ready
- busy  output  1  high whenever state != IDLE

## Operation
- States: IDLE, LOAD, ROUND, FINAL, OUT.
- IDLE: if key_ready=1 and (enc_req|dec_req): choose winner, latch mode, go LOAD. Else stay. key_ready is sampled only in IDLE.
- Arbitration: round-robin on a last_served flag. When both requests are present, the one not last served wins. last_served resets to decrypt, so encrypt wins the first tie. A single request always wins.
- LOAD: enc_grant or dec_grant (the winner's) =1, load_block=1, round_num=0, key_sel = 0 (enc) / NUM_ROUNDS (dec). Go ROUND with round_num=1.
- ROUND: round_en=1; key_sel = round_num (enc) / NUM_ROUNDS-round_num (dec). If round_num==NUM_ROUNDS-1, go FINAL; round_num increments on every ROUND exit.
- FINAL: round_en=1, final_round=1, round_num=NUM_ROUNDS, key_sel = NUM_ROUNDS (enc) / 0 (dec). Go OUT.
- OUT: out_valid=1, round_num holds NUM_ROUNDS. When out_ready=1: clear=1 that cycle, go IDLE, update last_served to the served mode.
- Requests arriving while busy are not granted until the next IDLE evaluation.
- round_num/key_sel arithmetic is unsigned RCNT_W bits and never wraps. In IDLE both are 0.
- In all cycles at most one of load_block and round_en is high, and at most one grant is high.

## Timing
- Reset: state=IDLE, last_served=decrypt, round_num=0, mode=0. All outputs 0 (grants, load_block, round_en, final_round, key_sel, out_valid, clear, busy).
- Reset mid-operation: next cycle is IDLE with the above values. No grant is reissued. A held request is re-arbitrated normally.
- Request sampled in IDLE at cycle T (key_ready=1): LOAD/grant at T+1, ROUND rounds 1..NUM_ROUNDS-1 at T+2..T+NUM_ROUNDS, FINAL at T+NUM_ROUNDS+1, out_valid from T+NUM_ROUNDS+2 (T+12 for default).
- out_ready low holds OUT indefinitely with all datapath strobes 0.
- Minimum back-to-back spacing: one IDLE cycle after the accepting OUT cycle, so 13 cycles per block with NUM_ROUNDS=10 and out_ready tied high.
- enc_req/dec_req dropped before grant: no grant is issued, and the sequencer stays IDLE.

## Test plan
- Reset, then enc_req=1, key_ready=1, out_ready=1 at T: enc_grant and load_block at T+1 with key_sel=0. key_sel 1..9 at T+2..T+10. final_round at T+11 with key_sel=10. out_valid and clear at T+12. busy falls at T+13.
- Single dec_req: mode=1. key_sel sequence is 10 (load), 9..1, 0 (final). round_num is 0..10.
- enc_req=dec_req=1 continuously, out_ready=1: grants alternate enc, dec, enc, dec, 13 cycles apart.
- key_ready=0 with enc_req=1 for 5 cycles: no grant, busy=0. key_ready rises: grant one cycle later.
- out_ready=0 for 4 cycles in OUT: out_valid stays 1, round_en/load_block 0, clear fires only on the cycle out_ready=1.
- n_rst=1 during ROUND (round_num=5): next cycle all outputs 0, state IDLE. A held enc_req is granted 2 cycles after reset release.
